// File: rtl/crosswalk_request_ctrl_pkg.sv
// traffic_pkg: shared traffic-light timing constants and crosswalk FSM state encoding
package traffic_pkg;
  localparam int CLK_HZ              = 50_000_000;
  localparam int CLK_DIV_1HZ         = CLK_HZ;
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int DEF_LOCKOUT_CYCLES  = 1_000_000;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;
endpackage

// File: rtl/crosswalk_request_ctrl_button_debouncer.sv
// button_debouncer: 2-flop synchronizer + stable-count debounce of raw_i -> level_o, one-cycle press_o on rising level
module button_debouncer
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, press_q, press_d, flip;
  always_comb begin
    flip    = sync_q[1] != level_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d   = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = level_q ^ flip;
    press_d = flip && !level_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end
  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/crosswalk_request_ctrl.sv
// crosswalk_request_ctrl: debounced walk-button request latch with ACK handshake, post-ACK lockout and saturating request count
module crosswalk_request_ctrl
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic             inputCLK,
  input  logic             RSTn,
  input  logic             BTN_RAW,
  input  logic             ACK,
  output logic             BTN_LEVEL,
  output logic             BTN_PRESS,
  output logic             REQ,
  output logic             LOCKED,
  output logic [CNT_W-1:0] REQ_CNT
);
  localparam int LW = LOCKOUT_CYCLES > 1 ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES > 0 ? LOCKOUT_CYCLES - 1 : 0);
  state_e           state_q, state_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic             req_q, req_d, locked_q, locked_d, press;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk_i  (inputCLK),
    .rst_ni (RSTn),
    .raw_i  (BTN_RAW),
    .level_o(BTN_LEVEL),
    .press_o(press)
  );
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    req_cnt_d = req_cnt_q;
    case (state_q)
      ST_IDLE: if (press) begin
        state_d   = ST_PENDING;
        req_cnt_d = req_cnt_q + CNT_W'(req_cnt_q != '1);
      end
      ST_PENDING: if (ACK) begin
        state_d = LOCKOUT_CYCLES > 0 ? ST_LOCKOUT : ST_IDLE;
        lock_d  = LOCK_LOAD;
      end
      ST_LOCKOUT: begin
        lock_d  = lock_q - LW'(lock_q != '0);
        state_d = lock_q == '0 ? ST_IDLE : ST_LOCKOUT;
      end
      default: state_d = ST_IDLE;
    endcase
    req_d    = state_d == ST_PENDING;
    locked_d = state_d == ST_LOCKOUT;
  end
  always_ff @(posedge inputCLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      lock_q    <= '0;
      req_cnt_q <= '0;
      req_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      req_cnt_q <= req_cnt_d;
      req_q     <= req_d;
      locked_q  <= locked_d;
    end
  end
  assign BTN_PRESS = press;
  assign REQ       = req_q;
  assign LOCKED    = locked_q;
  assign REQ_CNT   = req_cnt_q;
endmodule

// File: tb/tb_crosswalk_request_ctrl.sv
// tb_crosswalk_request_ctrl: directed scenarios plus random stimulus against a behavioural request/lockout model
module tb_crosswalk_request_ctrl;
  localparam int D = 4;
  localparam int L = 8;
  logic clk = 0, rst_n = 0, raw = 0, ack = 0, ack2 = 0;
  logic lvl, prs, req, lck, lvl2, prs2, req2, lck2;
  logic [7:0] cnt, cnt2;
  int errors = 0, checks = 0;
  crosswalk_request_ctrl #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CNT_W(8)) dut (
    .inputCLK(clk), .RSTn(rst_n), .BTN_RAW(raw), .ACK(ack),
    .BTN_LEVEL(lvl), .BTN_PRESS(prs), .REQ(req), .LOCKED(lck), .REQ_CNT(cnt));
  crosswalk_request_ctrl #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(0), .CNT_W(8)) dut0 (
    .inputCLK(clk), .RSTn(rst_n), .BTN_RAW(raw), .ACK(ack2),
    .BTN_LEVEL(lvl2), .BTN_PRESS(prs2), .REQ(req2), .LOCKED(lck2), .REQ_CNT(cnt2));
  always #5 clk = ~clk;
  // behavioural model: raw history gives the synchronized sample, a run of D
  // differing samples flips the level, lockout tracked as cycles remaining
  bit m_hist[$];
  bit m_run[$];
  bit m_lvl, m_prs, m_pend, m_s, m_old_prs;
  int m_lock, m_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_hist = '{1'b0, 1'b0};
      m_run.delete();
      m_lvl = 0; m_prs = 0; m_pend = 0; m_lock = 0; m_cnt = 0;
    end else begin
      m_s = m_hist.pop_front();
      m_hist.push_back(raw);
      m_old_prs = m_prs;
      m_prs = 0;
      if (m_s != m_lvl) m_run.push_back(m_s); else m_run.delete();
      if (m_run.size() == D) begin
        m_lvl = m_s;
        m_prs = m_s;
        m_run.delete();
      end
      if (m_lock > 0) m_lock--;
      else if (m_pend) begin
        if (ack) begin m_pend = 0; m_lock = L; end
      end else if (m_old_prs) begin
        m_pend = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    rst_n = 0; raw = 0; ack = 0; ack2 = 0;
    tick(3);
    checks++; if ({lvl, prs, req, lck} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b want=0000", {lvl, prs, req, lck}); end
    checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    rst_n = 1;
  endtask
  task automatic test_first_press;
    tick(2);
    raw = 1;
    tick(5);
    checks++; if (lvl !== 1'b0) begin errors++; $display("FAIL early_level got=%b want=0", lvl); end
    tick(1);
    checks++; if ({lvl, prs, req} !== 3'b110) begin errors++; $display("FAIL first_press got=%b want=110", {lvl, prs, req}); end
    tick(1);
    checks++; if ({prs, req} !== 2'b01) begin errors++; $display("FAIL first_req got=%b want=01", {prs, req}); end
    checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL first_cnt got=%0d want=1", cnt); end
  endtask
  task automatic test_handshake;
    raw = 0;
    tick(8);
    checks++; if ({lvl, req, cnt} !== {1'b0, 1'b1, 8'd1}) begin errors++; $display("FAIL hold_pending got=%b/%b/%0d want=0/1/1", lvl, req, cnt); end
    ack = 1; raw = 1;
    tick(1);
    ack = 0;
    checks++; if ({req, lck} !== 2'b01) begin errors++; $display("FAIL ack_enter got=%b want=01", {req, lck}); end
    for (int i = 2; i <= 8; i++) begin
      tick(1);
      checks++; if ({req, lck} !== 2'b01) begin errors++; $display("FAIL lockout_%0d got=%b want=01", i, {req, lck}); end
    end
    tick(1);
    checks++; if ({req, lck, cnt} !== {2'b00, 8'd1}) begin errors++; $display("FAIL lockout_exit got=%b/%b/%0d want=0/0/1", req, lck, cnt); end
    tick(2);
    checks++; if ({lvl, req, cnt} !== {1'b1, 1'b0, 8'd1}) begin errors++; $display("FAIL press_in_lockout got=%b/%b/%0d want=1/0/1", lvl, req, cnt); end
  endtask
  task automatic test_bounce;
    int n, at;
    raw = 0;
    tick(8);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      raw = (i / 2) % 2 == 0;
      tick(1);
      if (prs) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL bounce_quiet got=%0d pulses want=0", n); end
    raw = 1;
    at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (prs) begin n++; at = i; end
    end
    checks++; if (n !== 1 || at !== 6) begin errors++; $display("FAIL bounce_press got=%0d@%0d want=1@6", n, at); end
    checks++; if ({req, cnt} !== {1'b1, 8'd2}) begin errors++; $display("FAIL bounce_req got=%b/%0d want=1/2", req, cnt); end
  endtask
  task automatic test_simultaneous;
    raw = 0;
    tick(8);
    raw = 1;
    tick(6);
    checks++; if ({prs, req} !== 2'b11) begin errors++; $display("FAIL sim_pend_setup got=%b want=11", {prs, req}); end
    ack = 1;
    tick(1);
    ack = 0;
    checks++; if ({req, lck, cnt} !== {2'b01, 8'd2}) begin errors++; $display("FAIL sim_pend got=%b/%b/%0d want=0/1/2", req, lck, cnt); end
    tick(9);
    raw = 0;
    tick(8);
    raw = 1;
    tick(6);
    checks++; if ({prs, req, lck} !== 3'b100) begin errors++; $display("FAIL sim_idle_setup got=%b want=100", {prs, req, lck}); end
    ack = 1;
    tick(1);
    ack = 0;
    checks++; if ({req, cnt} !== {1'b1, 8'd3}) begin errors++; $display("FAIL sim_idle got=%b/%0d want=1/3", req, cnt); end
  endtask
  task automatic test_reset_mid_lockout;
    ack = 1;
    tick(1);
    ack = 0;
    tick(3);
    checks++; if (lck !== 1'b1) begin errors++; $display("FAIL mid_lock_setup got=%b want=1", lck); end
    rst_n = 0;
    #1;
    checks++; if ({lvl, prs, req, lck, cnt} !== 12'b0) begin errors++; $display("FAIL async_reset got=%b%b%b%b/%0d want=0", lvl, prs, req, lck, cnt); end
    tick(2);
    checks++; if ({lvl, prs, req, lck, cnt} !== 12'b0) begin errors++; $display("FAIL held_reset got=%b%b%b%b/%0d want=0", lvl, prs, req, lck, cnt); end
    rst_n = 1;
    tick(5);
    checks++; if (prs !== 1'b0) begin errors++; $display("FAIL rel_early got=%b want=0", prs); end
    tick(1);
    checks++; if (prs !== 1'b1) begin errors++; $display("FAIL rel_press got=%b want=1", prs); end
    tick(1);
    checks++; if ({req, cnt} !== {1'b1, 8'd1}) begin errors++; $display("FAIL rel_req got=%b/%0d want=1/1", req, cnt); end
  endtask
  task automatic test_random;
    int hold = 0;
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      checks++;
      if ({lvl, prs, req, lck} !== {m_lvl, m_prs, m_pend, m_lock > 0} || cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL random_c%0d got=%b%b%b%b/%0d want=%b%b%b%b/%0d", c, lvl, prs, req, lck, cnt, m_lvl, m_prs, m_pend, m_lock > 0, m_cnt);
      end
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 599) == 0) rst_n = 0;
      ack = $urandom_range(0, 5) == 0;
      if (hold == 0) begin
        raw = $urandom_range(0, 1);
        hold = $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : $urandom_range(4, 12);
      end
      hold--;
    end
    rst_n = 1; ack = 0;
  endtask
  task automatic test_saturation;
    int want;
    rst_n = 0; raw = 0; ack = 0; ack2 = 0;
    tick(2);
    rst_n = 1;
    tick(2);
    for (int i = 1; i <= 260; i++) begin
      raw = 1;
      tick(7);
      want = i > 255 ? 255 : i;
      checks++; if ({req2, lck2, cnt2} !== {2'b10, 8'(want)}) begin errors++; $display("FAIL sat_%0d got=%b/%b/%0d want=1/0/%0d", i, req2, lck2, cnt2, want); end
      ack2 = 1;
      tick(1);
      ack2 = 0;
      raw = 0;
      tick(7);
    end
    checks++; if ({req2, cnt2} !== {1'b0, 8'd255}) begin errors++; $display("FAIL sat_final got=%b/%0d want=0/255", req2, cnt2); end
  endtask
  initial begin
    test_reset();
    test_first_press();
    test_handshake();
    test_bounce();
    test_simultaneous();
    test_reset_mid_lockout();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
